// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Shared definitions for the time-of-day counter: the load FSM state
//   encoding, BCD digit limits and the load legality check.
// ---------------------------------------------------------------------------
package clock_pkg;

    // RUN accepts ticks and loads; CHECK validates a captured load for one cycle.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CHECK = 1'b1
    } ck_state_e;

    localparam logic [3:0] UNITS_MAX     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;
    localparam logic [3:0] HOUR_TENS_MAX = 4'd2;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;

    // Once both nibbles are decimal, BCD ordering equals numeric ordering,
    // so the upper bound can be checked directly on the packed byte.
    function automatic logic bcd_legal(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// ---------------------------------------------------------------------------
// clock_timekeeper_if
//   Time-load port of the timekeeper.
//   set_valid    : requester has a time value on set_hours/minutes/seconds
//   set_ready    : timekeeper can accept a load this cycle
//   set_hours/minutes/seconds : packed BCD {tens,units}
//
//   Handshake: a load transfers on any rising clock edge where
//   set_valid && set_ready. The requester holds its values stable while
//   set_valid is high and not yet accepted; set_ready does not depend on
//   set_valid.
// ---------------------------------------------------------------------------
interface clock_timekeeper_if;
    logic       set_valid;
    logic       set_ready;
    logic [7:0] set_hours;
    logic [7:0] set_minutes;
    logic [7:0] set_seconds;

    modport master (
        output set_valid, set_hours, set_minutes, set_seconds,
        input  set_ready
    );

    modport slave (
        input  set_valid, set_hours, set_minutes, set_seconds,
        output set_ready
    );
endinterface

// File: rtl/clock_timekeeper_bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
//   One BCD digit of the time-of-day counter.
//   clk, rst    : clock, asynchronous active-high reset (digit -> 0)
//   inc_i       : advance the digit by one
//   wrap_i      : force the next increment to wrap to 0 (hours 23 -> 00)
//   load_i      : take load_val_i (has priority over inc_i)
//   load_val_i  : value to load
//   q_o         : registered digit
//   d_o         : next-state value of the digit
//   carry_o     : this increment wraps the digit to 0
// ---------------------------------------------------------------------------
module bcd_digit_counter
    import clock_pkg::*;
#(
    parameter logic [3:0] MAX = UNITS_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       wrap_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] q_o,
    output logic [3:0] d_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       at_top;

    assign at_top = wrap_i || (digit_q == MAX);

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (inc_i) begin
            digit_d = at_top ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q_o     = digit_q;
    assign d_o     = digit_d;
    assign carry_o = inc_i && at_top;

endmodule

// File: rtl/clock_timekeeper.sv
// ---------------------------------------------------------------------------
// clock_timekeeper
//   24-hour BCD time-of-day counter advanced by a 1 Hz one-cycle strobe,
//   with a validated load port and display-side wrap pulses.
//   sys_clk, rst     : sole clock, asynchronous active-high reset
//   tick_en          : 1 Hz strobe; each one advances the time by a second
//   set_bus          : load port (valid/ready), see clock_timekeeper_if
//   hours/minutes/seconds_bcd : registered current time, packed BCD
//   minute_pulse     : one cycle when seconds wrap 59 -> 00
//   day_wrap         : one cycle when time wraps 23:59:59 -> 00:00:00
//   set_err          : one cycle when a captured load is rejected
//   dbg_state        : current load FSM state
//   Optional (CLOCK_TIMEKEEPER_ALARM_EN defined):
//   alarm_hours/minutes, alarm_ack inputs, alarm_on output, and parameter
//   ALARM_LEN (ticks alarm_on stays high, 1..255).
// ---------------------------------------------------------------------------
module clock_timekeeper
    import clock_pkg::*;
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
#(
    parameter int unsigned ALARM_LEN = 60
)
`endif
(
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 tick_en,
    clock_timekeeper_if.slave    set_bus,
    output logic [7:0]           hours_bcd,
    output logic [7:0]           minutes_bcd,
    output logic [7:0]           seconds_bcd,
    output logic                 minute_pulse,
    output logic                 day_wrap,
    output logic                 set_err,
`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    input  logic [7:0]           alarm_hours,
    input  logic [7:0]           alarm_minutes,
    input  logic                 alarm_ack,
    output logic                 alarm_on,
`endif
    output ck_state_e            dbg_state
);

    // ---------------- load FSM ----------------
    ck_state_e state_q, state_d;
    logic      accept;
    logic      in_check;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (set_bus.set_valid) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        in_check = (state_q == ST_CHECK);
        accept   = (state_q == ST_RUN) && set_bus.set_valid;
    end

    assign set_bus.set_ready = (state_q == ST_RUN);
    assign dbg_state         = state_q;

    // ---------------- holding registers, pending tick, pulses ----------------
    logic [7:0] hold_h_q, hold_m_q, hold_s_q;
    logic       pend_q, pend_d;
    logic       set_err_q, minute_pulse_q, day_wrap_q;
    logic       load_ok, load_en, inc;

    assign load_ok = bcd_legal(hold_h_q, HOUR_MAX) && bcd_legal(hold_m_q, MIN_MAX)
                     && bcd_legal(hold_s_q, SEC_MAX);
    assign load_en = in_check && load_ok;

    // A strobe seen during CHECK only survives a rejected load; it is then
    // applied on the next RUN cycle, merged with any coincident strobe.
    assign pend_d = in_check && !load_ok && tick_en;
    assign inc    = !in_check && (tick_en || pend_q);

    logic [3:0] sec_u_q, sec_t_q, min_u_q, min_t_q, hr_u_q, hr_t_q;
    logic [3:0] sec_u_d, sec_t_d, min_u_d, min_t_d, hr_u_d, hr_t_d;
    logic       sec_u_c, sec_t_c, min_u_c, min_t_c, hr_u_c, hr_t_c;
    logic       hr_wrap;

    // Hours wrap at 23 rather than at their digit maxima.
    assign hr_wrap = (hr_t_q == 4'd2) && (hr_u_q == 4'd3);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            hold_h_q       <= 8'h00;
            hold_m_q       <= 8'h00;
            hold_s_q       <= 8'h00;
            pend_q         <= 1'b0;
            set_err_q      <= 1'b0;
            minute_pulse_q <= 1'b0;
            day_wrap_q     <= 1'b0;
        end else begin
            if (accept) begin
                hold_h_q <= set_bus.set_hours;
                hold_m_q <= set_bus.set_minutes;
                hold_s_q <= set_bus.set_seconds;
            end
            pend_q         <= pend_d;
            set_err_q      <= in_check && !load_ok;
            minute_pulse_q <= sec_t_c;
            day_wrap_q     <= hr_t_c;
        end
    end

    // ---------------- digit chain ----------------
    bcd_digit_counter #(.MAX(UNITS_MAX)) u_sec_u (
        .clk(sys_clk), .rst(rst), .inc_i(inc), .wrap_i(1'b0),
        .load_i(load_en), .load_val_i(hold_s_q[3:0]),
        .q_o(sec_u_q), .d_o(sec_u_d), .carry_o(sec_u_c));

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_t (
        .clk(sys_clk), .rst(rst), .inc_i(sec_u_c), .wrap_i(1'b0),
        .load_i(load_en), .load_val_i(hold_s_q[7:4]),
        .q_o(sec_t_q), .d_o(sec_t_d), .carry_o(sec_t_c));

    bcd_digit_counter #(.MAX(UNITS_MAX)) u_min_u (
        .clk(sys_clk), .rst(rst), .inc_i(sec_t_c), .wrap_i(1'b0),
        .load_i(load_en), .load_val_i(hold_m_q[3:0]),
        .q_o(min_u_q), .d_o(min_u_d), .carry_o(min_u_c));

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_t (
        .clk(sys_clk), .rst(rst), .inc_i(min_u_c), .wrap_i(1'b0),
        .load_i(load_en), .load_val_i(hold_m_q[7:4]),
        .q_o(min_t_q), .d_o(min_t_d), .carry_o(min_t_c));

    bcd_digit_counter #(.MAX(UNITS_MAX)) u_hr_u (
        .clk(sys_clk), .rst(rst), .inc_i(min_t_c), .wrap_i(hr_wrap),
        .load_i(load_en), .load_val_i(hold_h_q[3:0]),
        .q_o(hr_u_q), .d_o(hr_u_d), .carry_o(hr_u_c));

    bcd_digit_counter #(.MAX(HOUR_TENS_MAX)) u_hr_t (
        .clk(sys_clk), .rst(rst), .inc_i(hr_u_c), .wrap_i(hr_wrap),
        .load_i(load_en), .load_val_i(hold_h_q[7:4]),
        .q_o(hr_t_q), .d_o(hr_t_d), .carry_o(hr_t_c));

    assign hours_bcd    = {hr_t_q, hr_u_q};
    assign minutes_bcd  = {min_t_q, min_u_q};
    assign seconds_bcd  = {sec_t_q, sec_u_q};
    assign minute_pulse = minute_pulse_q;
    assign day_wrap     = day_wrap_q;
    assign set_err      = set_err_q;

`ifdef CLOCK_TIMEKEEPER_ALARM_EN
    // ---------------- alarm ----------------
    logic       alarm_on_q;
    logic [7:0] alarm_cnt_q;
    logic       alarm_hit;
    logic       unused_next;

    // Only a tick that rolls seconds to 00 can fire; loads never carry.
    assign alarm_hit = sec_t_c && ({hr_t_d, hr_u_d} == alarm_hours)
                       && ({min_t_d, min_u_d} == alarm_minutes);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            alarm_on_q  <= 1'b0;
            alarm_cnt_q <= 8'd0;
        end else if (alarm_ack) begin
            alarm_on_q  <= 1'b0;
            alarm_cnt_q <= 8'd0;
        end else if (alarm_hit) begin
            alarm_on_q  <= 1'b1;
            alarm_cnt_q <= 8'(ALARM_LEN);
        end else if (alarm_on_q && inc) begin
            if (alarm_cnt_q <= 8'd1) begin
                alarm_on_q <= 1'b0;
            end
            alarm_cnt_q <= alarm_cnt_q - 8'd1;
        end
    end

    assign alarm_on    = alarm_on_q;
    assign unused_next = ^{sec_t_d, sec_u_d};
`else
    logic unused_next;
    assign unused_next = ^{hr_t_d, hr_u_d, min_t_d, min_u_d, sec_t_d, sec_u_d};
`endif

endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Time-of-day counter for the digital clock. Consumes the one-cycle 1 Hz enable strobe produced by the clock divider, advances a 24-hour BCD time (hh:mm:ss) on each strobe, and accepts new time values through a valid/ready load port. Drives the display path with registered BCD digits plus minute and day-wrap pulses.

## Interface
Parameters:
- ALARM_LEN, 60: number of ticks alarm_on stays high (compiled only with ALARM_EN); legal 1..255.

Ports:
- sys_clk  in  1  system clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- tick_en  in  1  one-cycle 1 Hz strobe from the clock divider.
- set_valid  in  1  load request.
- set_ready  out  1  block can accept a load.
- set_hours  in  8  BCD hours, {tens,units}.
- set_minutes  in  8  BCD minutes.
- set_seconds  in  8  BCD seconds.
- hours_bcd  out  8  current hours, BCD.
- minutes_bcd  out  8  current minutes, BCD.
- seconds_bcd  out  8  current seconds, BCD.
- minute_pulse  out  1  one cycle when seconds wrap 59->00.
- day_wrap  out  1  one cycle when time wraps 23:59:59->00:00:00.
- set_err  out  1  one cycle when a load is rejected.
- alarm_hours, alarm_minutes  in  8 each  BCD alarm time (ALARM_EN only).
- alarm_ack  in  1  clears alarm_on (ALARM_EN only).
- alarm_on  out  1  alarm active (ALARM_EN only).

## Operation
- FSM states: RUN, CHECK. Reset enters RUN.
- RUN: set_ready=1. tick_en=1 increments time. set_valid&set_ready captures set_* into holding registers, moves to CHECK.
- CHECK (exactly one cycle): set_ready=0. Load is legal iff every nibble <=9, hours<=0x23, minutes<=0x59, seconds<=0x59. Legal: time registers take held values. Illegal: time unchanged, set_err pulses. Always returns to RUN.
- tick_en during CHECK is latched in a single pending bit; on a legal load the pending tick is discarded; on an illegal load it is applied in the following RUN cycle. tick_en coincident with that pending application is dropped (strobes are >=1000 cycles apart in practice).
- tick_en and set_valid in the same RUN cycle: tick applied, load captured; load then overwrites per CHECK rules.
- Increment: seconds units 9->0 carries to tens; seconds tens 5->0 carries to minutes; minutes identical; hours 23->00, units 9->0 carries to tens otherwise.
- Reset: all time digits 0x00, FSM RUN, pending bit 0, all pulses 0, set_ready 1 after reset deasserts, alarm_on 0.
- Reset asserted mid-CHECK aborts the load; no set_err.

## Timing
- tick_en high at cycle N -> digits updated at N+1; minute_pulse/day_wrap high only at N+1.
- set accepted at N -> CHECK at N+1 -> new digits or set_err at N+2; set_ready high again at N+2.
- All outputs registered; no combinational input->output path except none (set_ready decoded from state register).

## Configuration
- CLOCK_TIMEKEEPER_ALARM_EN defined: alarm ports present. When a tick produces seconds 00 with hours/minutes equal to alarm_hours/alarm_minutes, alarm_on rises at N+1, stays high for ALARM_LEN ticks or until alarm_ack (ack wins same cycle). A match during active alarm restarts the count. Loads never trigger the alarm.
- Undefined: alarm ports, ALARM_LEN logic and alarm_on absent; no alarm state.

## Structure
- Package clock_pkg: FSM state enum, BCD limit constants (SEC_TENS_MAX=5, MIN_TENS_MAX=5, HOUR_MAX=8'h23), BCD legality function.
- Sub-module bcd_digit_counter: one BCD digit with parameterized max, inc-in, load, carry-out; six instances, hours tens/units with wrap override at 23.

## Test plan
- Reset, 60 ticks -> seconds 0x00, minutes 0x01, minute_pulse once at tick 60.
- Load 23:59:59, one tick -> 00:00:00, day_wrap and minute_pulse high same cycle.
- Load 0x24:00:00 -> set_err one cycle at N+2, time unchanged, set_ready back high.
- Load 12:34:56 with tick_en in CHECK cycle -> 12:34:56 held, no tick applied; repeat with illegal 0x1A -> old time +1 s.
- Reset asserted during CHECK -> 00:00:00, no set_err, set_ready 1 after release.
- ALARM_EN, alarm 07:30, load 07:29:59, tick -> alarm_on; ALARM_LEN=3 -> low after 3 ticks; alarm_ack mid-window -> low next cycle.
